// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the slave interface slice.
// Holds HTRANS / HSIZE / HRESP encodings and the slave FSM state type.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // HSIZE encodings (larger sizes are not supported by this slave)
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_size_decode.sv
// Combinational transfer-size decoder.
// Ports:
//   hsize    - AHB HSIZE of the address phase
//   haddr_lo - HADDR[1:0] of the address phase
//   strb     - byte-lane enables for the backend (0 for unsupported sizes)
//   illegal  - size > word, or address misaligned for the size
module ahb_size_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  output logic [3:0] strb,
  output logic       illegal
);

  always_comb begin
    strb    = '0;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << haddr_lo;
      HSIZE_HALF: begin
        strb    = haddr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = haddr_lo[0];
      end
      HSIZE_WORD: begin
        strb    = 4'b1111;
        illegal = |haddr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end bridging to a simple req/ack backend.
// Parameters:
//   TIMEOUT - max ACCESS cycles without bus_ack before an ERROR response (1..255)
//   ADDR_W  - width of bus_addr
// Ports:
//   HCLK, HRESETn                 - clock, async active-low reset
//   HSEL..HWDATA                  - AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA      - AHB-Lite slave outputs
//   bus_req..bus_strb             - backend request (held while bus_req=1)
//   bus_ack, bus_err, bus_rdata   - backend response, sampled only in ACCESS
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_strb,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       addr_phase_ok;
  logic       timeout_hit;
  logic [3:0] dec_strb;
  logic       dec_illegal;

  assign accept        = HSEL & HREADY & HTRANS[1];
  assign addr_phase_ok = (state == ST_IDLE) || (state == ST_DONE);
  assign timeout_hit   = (wait_cnt == 8'(TIMEOUT - 1));
  assign bus_wdata     = HWDATA;

  ahb_size_decode u_size_decode (
    .hsize    (HSIZE),
    .haddr_lo (HADDR[1:0]),
    .strb     (dec_strb),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    bus_req   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nx = dec_illegal ? ST_ERR1 : ST_ACCESS;
        else        state_nx = ST_IDLE;
      end
      ST_ACCESS: begin
        bus_req   = 1'b1;
        HREADYOUT = 1'b0;
        // ack wins over a timeout landing in the same cycle
        if (bus_ack)          state_nx = bus_err ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_nx = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP    = HRESP_ERROR;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt  <= '0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_strb  <= '0;
      HRDATA    <= '0;
    end else begin
      // held at zero outside ACCESS, so every ACCESS entry starts from zero
      if (state != ST_ACCESS) wait_cnt <= '0;
      else if (!bus_ack)      wait_cnt <= wait_cnt + 8'd1;

      if (addr_phase_ok && accept) begin
        bus_write <= HWRITE;
        bus_addr  <= {HADDR[ADDR_W-1:2], 2'b00};
        bus_strb  <= dec_strb;
      end

      if (state == ST_ACCESS && bus_ack && !bus_err) HRDATA <= bus_rdata;
    end
  end

  // HTRANS[0] and HADDR bits above ADDR_W carry no meaning for this slave
  logic unused_bits;
  if (ADDR_W < 32) begin : g_unused_hi
    assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_W]};
  end else begin : g_unused_lo
    assign unused_bits = HTRANS[0];
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
module tb_ahb_slave_if;
  import ahb_pkg::*;

  localparam int unsigned TMO = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE = 3'd0;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        bus_req;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  ahb_slave_if #(.TIMEOUT(TMO), .ADDR_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 HCLK = ~HCLK;

  int unsigned cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad = 0;

  // One expected-output record per clock cycle of a transfer's data phase
  typedef struct {
    int unsigned cyc;
    logic        acc;
    logic        rdy;
    logic        resp;
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] hrdata;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] m_rdata = '0;

  // Lanes touched: 2^size bytes starting at the size-aligned byte offset
  function automatic logic [3:0] exp_strb(input logic [2:0] size, input logic [1:0] lo);
    int unsigned nbytes = 1 << size;
    int unsigned a = lo;
    int unsigned base = a - (a % nbytes);
    return 4'(((1 << nbytes) - 1) << base);
  endfunction

  function automatic logic exp_illegal(input logic [2:0] size, input logic [1:0] lo);
    int unsigned a = lo;
    if (size > 3'd2) return 1'b1;
    return (a % (1 << size)) != 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic push_rec(input int unsigned c, input logic acc, input logic rdy, input logic resp,
                          input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    exp_t e;
    e.cyc    = c;
    e.acc    = acc;
    e.rdy    = rdy;
    e.resp   = resp;
    e.wr     = wr;
    e.addr   = addr[15:0] & 16'hFFFC;
    e.strb   = acc ? exp_strb(size, addr[1:0]) : 4'b0000;
    e.wdata  = wdata;
    e.hrdata = m_rdata;
    q.push_back(e);
  endtask

  always @(negedge HCLK) begin
    if (HRESETn && q.size() > 0 && q[0].cyc == cyc) begin
      cur = q.pop_front();
      check("bus_req", bus_req, cur.acc);
      check("hreadyout", HREADYOUT, cur.rdy);
      check("hresp", HRESP, cur.resp);
      check("hrdata", HRDATA, cur.hrdata);
      if (cur.acc) begin
        check("bus_write", bus_write, cur.wr);
        check("bus_addr", bus_addr, cur.addr);
        check("bus_strb", bus_strb, cur.strb);
        check("bus_wdata", bus_wdata, cur.wdata);
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HREADY = 1'b1; HTRANS = HTRANS_IDLE;
  endtask

  // Looks like a valid transfer; must be ignored while an error is signalled
  task automatic drive_bogus();
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_WORD;
    HADDR = $urandom & 32'hFFFF_FFFC; HWRITE = 1'($urandom_range(0, 1));
  endtask

  task automatic noise_ack();
    bus_ack = 1'($urandom_range(0, 1)); bus_err = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
  endtask

  // Address phase in the current cycle; returns in the last cycle of the
  // transfer's response, where the next address phase may be driven.
  // delay: ACCESS cycle in which the backend acks; 0 or > TMO means never.
  task automatic run_xfer(input logic sel, input logic rdy, input logic [1:0] trans,
                          input logic [2:0] size, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input int unsigned delay,
                          input logic err, input logic [31:0] rdata);
    int unsigned t = cyc;
    int unsigned n_acc;
    logic acked;
    HSEL = sel; HREADY = rdy; HTRANS = trans; HSIZE = size; HADDR = addr;
    HWRITE = wr; HWDATA = $urandom;
    noise_ack();
    if (!(sel && rdy && trans[1])) begin
      push_rec(t + 1, 1'b0, 1'b1, 1'b0, wr, addr, size, wdata);
      step(); drive_idle();
      return;
    end
    if (exp_illegal(size, addr[1:0])) begin
      push_rec(t + 1, 1'b0, 1'b0, 1'b1, wr, addr, size, wdata);
      push_rec(t + 2, 1'b0, 1'b1, 1'b1, wr, addr, size, wdata);
      push_rec(t + 3, 1'b0, 1'b1, 1'b0, wr, addr, size, wdata);
      step(); drive_bogus(); noise_ack();
      step(); drive_bogus(); noise_ack();
      step(); drive_idle();
      return;
    end
    acked = (delay >= 1 && delay <= TMO);
    n_acc = acked ? delay : TMO;
    for (int unsigned i = 1; i <= n_acc; i++)
      push_rec(t + i, 1'b1, 1'b0, 1'b0, wr, addr, size, wdata);
    if (acked && !err) begin
      m_rdata = rdata;
      push_rec(t + n_acc + 1, 1'b0, 1'b1, 1'b0, wr, addr, size, wdata);
    end else begin
      push_rec(t + n_acc + 1, 1'b0, 1'b0, 1'b1, wr, addr, size, wdata);
      push_rec(t + n_acc + 2, 1'b0, 1'b1, 1'b1, wr, addr, size, wdata);
      push_rec(t + n_acc + 3, 1'b0, 1'b1, 1'b0, wr, addr, size, wdata);
    end
    for (int unsigned i = 1; i <= n_acc; i++) begin
      step();
      HSEL = 1'($urandom_range(0, 1)); HREADY = 1'b0; HTRANS = 2'($urandom_range(0, 3));
      HADDR = $urandom; HWDATA = wdata;
      bus_ack   = acked && (i == delay);
      bus_err   = bus_ack ? err : 1'($urandom_range(0, 1));
      bus_rdata = bus_ack ? rdata : $urandom;
    end
    step();
    if (acked && !err) begin
      drive_idle(); noise_ack();
      return;
    end
    drive_bogus(); noise_ack();
    step(); drive_bogus(); noise_ack();
    step(); drive_idle();
  endtask

  logic [2:0]  r_sz;
  logic [31:0] r_addr;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // model pins
    check("model_strb_byte3", exp_strb(3'd0, 2'd3), 32'h8);
    check("model_strb_half2", exp_strb(3'd1, 2'd2), 32'hC);
    check("model_strb_word", exp_strb(3'd2, 2'd0), 32'hF);
    check("model_illegal_word2", exp_illegal(3'd2, 2'd2), 32'h1);
    check("model_illegal_half1", exp_illegal(3'd1, 2'd1), 32'h1);
    check("model_illegal_size3", exp_illegal(3'd3, 2'd0), 32'h1);
    check("model_legal_byte3", exp_illegal(3'd0, 2'd3), 32'h0);

    drive_idle();
    repeat (3) step();
    check("rst_hreadyout", HREADYOUT, 32'h1);
    check("rst_hresp", HRESP, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_bus_req", bus_req, 32'h0);
    check("rst_bus_write", bus_write, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_strb", bus_strb, 32'h0);
    HRESETn = 1'b1;
    step();

    // word write, ack in third ACCESS cycle
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h0000_0104, 1'b1, 32'hDEADBEEF,
             3, 1'b0, 32'h0);
    #2;
    check("w104_done_ready", HREADYOUT, 32'h1);
    check("w104_bus_addr", bus_addr, 32'h0104);
    check("w104_bus_strb", bus_strb, 32'hF);
    // byte read at offset 3, pipelined in DONE
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_BYTE, 32'h0000_0203, 1'b0, 32'h0,
             1, 1'b0, 32'h11223344);
    #2;
    check("r203_hrdata", HRDATA, 32'h11223344);
    check("r203_bus_strb", bus_strb, 32'h8);
    check("r203_bus_addr", bus_addr, 32'h0200);
    // misaligned word
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h0000_0002, 1'b1, 32'h0,
             1, 1'b0, 32'h0);
    // backend never acks
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_WORD, 32'h0000_0010, 1'b0, 32'h0,
             0, 1'b0, 32'h0);
    // back-to-back writes then an IDLE transfer
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_HALF, 32'h0000_0012, 1'b1, 32'hA5A5_0001,
             1, 1'b0, 32'h0);
    run_xfer(1'b1, 1'b1, HTRANS_NONSEQ, HSIZE_BYTE, 32'h0000_0041, 1'b1, 32'hA5A5_0002,
             1, 1'b0, 32'h0);
    run_xfer(1'b1, 1'b1, HTRANS_IDLE, HSIZE_WORD, 32'h0000_0080, 1'b1, 32'h0,
             1, 1'b0, 32'h0);
    // backend error, ack on the timeout boundary cycle
    run_xfer(1'b1, 1'b1, HTRANS_SEQ, HSIZE_WORD, 32'h0000_0020, 1'b0, 32'h0,
             2, 1'b1, 32'h0);
    run_xfer(1'b1, 1'b1, HTRANS_SEQ, HSIZE_WORD, 32'h0000_0024, 1'b0, 32'h0,
             TMO, 1'b0, 32'h5555_AAAA);

    for (int k = 0; k < 300; k++) begin
      r_sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r_addr = $urandom;
      if (r_sz < 3'd3 && $urandom_range(0, 2) != 0)
        r_addr = r_addr & ~(32'((1 << r_sz) - 1));
      run_xfer(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
               2'($urandom_range(0, 3)), r_sz, r_addr, 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 5), 1'($urandom_range(0, 4) == 0), $urandom);
    end

    // reset in the middle of an ACCESS
    HSEL = 1'b1; HREADY = 1'b1; HTRANS = HTRANS_NONSEQ; HSIZE = HSIZE_WORD;
    HADDR = 32'h0000_0040; HWRITE = 1'b1; bus_ack = 1'b0;
    step();
    drive_idle(); bus_ack = 1'b0;
    check("mid_rst_pre_req", bus_req, 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_bus_req", bus_req, 32'h0);
    check("mid_rst_hreadyout", HREADYOUT, 32'h1);
    check("mid_rst_hresp", HRESP, 32'h0);
    check("mid_rst_hrdata", HRDATA, 32'h0);
    check("mid_rst_bus_write", bus_write, 32'h0);
    check("mid_rst_bus_addr", bus_addr, 32'h0);
    check("mid_rst_bus_strb", bus_strb, 32'h0);
    bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'hCAFE_F00D;
    step();
    HRESETn = 1'b1;
    step();
    check("post_rst_bus_req", bus_req, 32'h0);
    check("post_rst_hreadyout", HREADYOUT, 32'h1);
    check("post_rst_hrdata", HRDATA, 32'h0);
    bus_ack = 1'b0;
    step();
    check("records_left", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
